// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Time-shares one external combinational ALU among NREQ requesters. A
//   round-robin arbiter picks one request at a time. Its operands are latched
//   and presented to the ALU for exactly one cycle. The ALU outputs are
//   captured and returned on a single tagged response channel. Only one
//   operation is in flight, so throughput is at most one op per three cycles.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake; req_ready is a one-hot
//                            accept pulse, asserted only while idle
//   req_srca, req_regdata2,
//   req_immext, req_alusrc,
//   req_ctrl                 per-requester operands, slice i = [i*W +: W]
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_result,
//   rsp_zero, rsp_err        owner index, captured ALU outputs, illegal-ctrl flag
//   alu_*                    operand bus to the shared ALU (zero unless issuing)
//   alu_result, alu_zero     combinational ALU outputs
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_srca,
    input  logic [NREQ*W-1:0] req_regdata2,
    input  logic [NREQ*W-1:0] req_immext,
    input  logic [NREQ-1:0]   req_alusrc,
    input  logic [NREQ*3-1:0] req_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [W-1:0]      alu_srca,
    output logic [W-1:0]      alu_regdata2,
    output logic [W-1:0]      alu_immext,
    output logic              alu_alusrc,
    output logic [2:0]        alu_ctrl,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [IDW:0]   NREQ_W   = NREQ[IDW:0];
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [W-1:0]   srca_q, regdata2_q, immext_q;
    logic           alusrc_q;
    logic [2:0]     ctrl_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   result_q;
    logic           zero_q;
    logic           err_q;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    logic           accept;
    logic           ctrl_illegal;

    // Per-requester views of the flattened operand buses.
    logic [W-1:0] srca_arr     [NREQ];
    logic [W-1:0] regdata2_arr [NREQ];
    logic [W-1:0] immext_arr   [NREQ];
    logic [2:0]   ctrl_arr     [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign srca_arr[gi]     = req_srca[gi*W +: W];
            assign regdata2_arr[gi] = req_regdata2[gi*W +: W];
            assign immext_arr[gi]   = req_immext[gi*W +: W];
            assign ctrl_arr[gi]     = req_ctrl[gi*3 +: 3];
        end
    endgenerate

    // Round-robin search: scan offsets from the highest down so the lowest
    // offset from the pointer (the closest candidate) is the last one written.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + k[IDW:0];
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        case (ctrl_q)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: ctrl_illegal = 1'b0;
            default:                                ctrl_illegal = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = S_ISSUE;
                    ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            srca_q     <= '0;
            regdata2_q <= '0;
            immext_q   <= '0;
            alusrc_q   <= 1'b0;
            ctrl_q     <= '0;
            id_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                srca_q     <= srca_arr[grant_idx];
                regdata2_q <= regdata2_arr[grant_idx];
                immext_q   <= immext_arr[grant_idx];
                alusrc_q   <= req_alusrc[grant_idx];
                ctrl_q     <= ctrl_arr[grant_idx];
                id_q       <= grant_idx;
            end
            if (state_q == S_ISSUE) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                err_q    <= ctrl_illegal;
            end
        end
    end

    // The ALU sees operands only in the issue cycle; the response fields are
    // gated so nothing leaks out before the result is actually valid.
    always_comb begin
        alu_srca     = '0;
        alu_regdata2 = '0;
        alu_immext   = '0;
        alu_alusrc   = 1'b0;
        alu_ctrl     = '0;
        if (state_q == S_ISSUE) begin
            alu_srca     = srca_q;
            alu_regdata2 = regdata2_q;
            alu_immext   = immext_q;
            alu_alusrc   = alusrc_q;
            alu_ctrl     = ctrl_q;
        end
    end

    always_comb begin
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_result = '0;
        rsp_zero   = 1'b0;
        rsp_err    = 1'b0;
        if (state_q == S_RESP) begin
            rsp_valid  = 1'b1;
            rsp_id     = id_q;
            rsp_result = result_q;
            rsp_zero   = zero_q;
            rsp_err    = err_q;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Drives per-requester op queues into alu_share_arbiter, plays the part of
//   the shared ALU, and checks every cycle against a round-robin reference.
//   Expected responses are queued at grant time and popped by a monitor.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int IDW  = 1;

    typedef struct packed {
        logic [2:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] rd2;
        logic [W-1:0] imm;
        logic         alusrc;
    } op_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   result;
        logic           zero;
        logic           err;
    } rsp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_srca;
    logic [NREQ*W-1:0] req_regdata2;
    logic [NREQ*W-1:0] req_immext;
    logic [NREQ-1:0]   req_alusrc;
    logic [NREQ*3-1:0] req_ctrl;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic [W-1:0]      alu_srca;
    logic [W-1:0]      alu_regdata2;
    logic [W-1:0]      alu_immext;
    logic              alu_alusrc;
    logic [2:0]        alu_ctrl;
    logic [W-1:0]      alu_result;
    logic              alu_zero;

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_srca     (req_srca),
        .req_regdata2 (req_regdata2),
        .req_immext   (req_immext),
        .req_alusrc   (req_alusrc),
        .req_ctrl     (req_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err),
        .alu_srca     (alu_srca),
        .alu_regdata2 (alu_regdata2),
        .alu_immext   (alu_immext),
        .alu_alusrc   (alu_alusrc),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU behaviour; illegal codes return an arbitrary but
    // deterministic value so the pass-through of the result is observable.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return a ^ b ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_ctrl, alu_srca, alu_alusrc ? alu_immext : alu_regdata2);
        alu_zero   = (alu_result == '0);
    end

    function automatic rsp_t predict_rsp(input int id, input op_t o);
        rsp_t e;
        logic [W-1:0] r;
        r        = ref_alu(o.ctrl, o.a, o.alusrc ? o.imm : o.rd2);
        e.id     = id[IDW-1:0];
        e.result = r;
        e.zero   = (r == '0);
        e.err    = !(o.ctrl inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101});
        return e;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus state.
    op_t             op_q [NREQ][$];
    op_t             cur_op [NREQ];
    logic [NREQ-1:0] cur_v    = '0;
    logic [NREQ-1:0] consumed = '0;
    int              rsp_mode = 1;   // 0 random, 1 always ready, 2 never ready
    rsp_t            exp_q [$];

    // Reference model state: stage 0 free, 1 operating, 2 responding.
    int  m_stage = 0;
    int  m_ptr   = 0;
    op_t m_op;

    // Requester/consumer driver; only this block writes DUT request inputs.
    initial begin
        req_valid    = '0;
        req_srca     = '0;
        req_regdata2 = '0;
        req_immext   = '0;
        req_alusrc   = '0;
        req_ctrl     = '0;
        rsp_ready    = 1'b0;
        for (int i = 0; i < NREQ; i++) cur_op[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (consumed[i]) begin
                    cur_v[i]    = 1'b0;
                    consumed[i] = 1'b0;
                end
                if (!cur_v[i] && op_q[i].size() > 0) begin
                    cur_op[i] = op_q[i].pop_front();
                    cur_v[i]  = 1'b1;
                end
                req_valid[i]          = cur_v[i];
                req_srca[i*W +: W]     = cur_op[i].a;
                req_regdata2[i*W +: W] = cur_op[i].rd2;
                req_immext[i*W +: W]   = cur_op[i].imm;
                req_alusrc[i]          = cur_op[i].alusrc;
                req_ctrl[i*3 +: 3]     = cur_op[i].ctrl;
            end
            case (rsp_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Reference model: grant prediction, bus/timing checks, expected pushes.
    logic [NREQ-1:0] m_exp_ready;
    int              m_g;
    int              m_c;
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_rst", req_ready, '0);
            m_stage = 0;
            m_ptr   = 0;
            exp_q.delete();
        end else begin
            m_exp_ready = '0;
            m_g         = -1;
            if (m_stage == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_c = (m_ptr + k) % NREQ;
                    if (m_g < 0 && req_valid[m_c]) m_g = m_c;
                end
            end
            if (m_g >= 0) m_exp_ready[m_g] = 1'b1;
            chk("req_ready", req_ready, m_exp_ready);
            chk("rsp_valid", rsp_valid, (m_stage == 2));
            if (m_stage == 1)
                chk("alu_bus", {alu_ctrl, alu_srca, alu_regdata2, alu_immext, alu_alusrc}, m_op);
            else
                chk("alu_bus_zero", {alu_ctrl, alu_srca, alu_regdata2, alu_immext, alu_alusrc}, '0);
            if (m_stage != 2)
                chk("rsp_fields_zero", {rsp_id, rsp_result, rsp_zero, rsp_err}, '0);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) consumed[i] = 1'b1;
            case (m_stage)
                0: if (m_g >= 0) begin
                    m_op = cur_op[m_g];
                    exp_q.push_back(predict_rsp(m_g, m_op));
                    m_ptr   = (m_g + 1) % NREQ;
                    m_stage = 1;
                end
                1: m_stage = 2;
                default: if (rsp_ready) m_stage = 0;
            endcase
        end
    end

    // Response monitor: compares whatever the DUT presents with the queue head.
    rsp_t mon_got;
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            mon_got = {rsp_id, rsp_result, rsp_zero, rsp_err};
            if (exp_q.size() == 0) begin
                chk("rsp_outstanding", exp_q.size(), 1);
            end else begin
                chk("rsp", mon_got, exp_q[0]);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    $display("rsp id=%0d result=%08h zero=%0b err=%0b", rsp_id, rsp_result,
                             rsp_zero, rsp_err);
                end
            end
        end
    end

    task automatic push(input int r, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] rd2, input logic [W-1:0] imm, input logic s);
        op_t o;
        o.ctrl   = c;
        o.a      = a;
        o.rd2    = rd2;
        o.imm    = imm;
        o.alusrc = s;
        op_q[r].push_back(o);
    endtask

    task automatic push_rand(input int r);
        logic [W-1:0] a;
        a = $urandom;
        push(r, 3'($urandom_range(0, 7)), a,
             ($urandom_range(0, 3) == 0) ? a : $urandom,
             ($urandom_range(0, 3) == 0) ? a : $urandom,
             1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    function automatic bit all_quiet();
        for (int i = 0; i < NREQ; i++) if (op_q[i].size() != 0) return 0;
        return (cur_v == '0) && (consumed == '0) && (exp_q.size() == 0) && (m_stage == 0);
    endfunction

    task automatic drain(input int budget);
        int c = 0;
        while (!all_quiet() && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got busy expected idle within %0d cycles", budget);
        end
    endtask

    // what: 0 wait for any req_ready, 1 wait for rsp_valid
    task automatic wait_for(input int what, input int budget);
        int c = 0;
        bit hit = 0;
        while (!hit && c < budget) begin
            @(negedge clk);
            #1;
            hit = (what == 0) ? (|req_ready) : rsp_valid;
            c++;
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_timeout: got no event expected event %0d within %0d cycles", what, budget);
        end
    endtask

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: got running expected finished at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // 1: basic ADD
        push(0, 3'b000, 32'd10, 32'd5, 32'd0, 1'b0);
        drain(50);

        // 2: simultaneous requests after reset, twice
        do_reset();
        push(0, 3'b001, 32'd15, 32'd15, 32'd0, 1'b0);
        push(1, 3'b000, 32'd20, 32'd0, 32'd7, 1'b1);
        drain(50);
        push(0, 3'b000, 32'd1, 32'd2, 32'd0, 1'b0);
        push(1, 3'b010, 32'hF0F0, 32'hFF00, 32'd0, 1'b0);
        drain(50);

        // 3: back-pressure holds the response; a pending request waits
        rsp_mode = 2;
        push(1, 3'b011, 32'h0000_FFFF, 32'd0, 32'h00FF_00FF, 1'b1);
        wait_for(0, 20);
        push(0, 3'b000, 32'd3, 32'd4, 32'd0, 1'b0);
        repeat (7) @(negedge clk);
        rsp_mode = 1;
        drain(50);

        // 4: SLT and an illegal control code
        push(0, 3'b101, 32'd5, 32'd10, 32'd0, 1'b0);
        push(1, 3'b101, 32'd30, 32'd0, 32'd10, 1'b1);
        push(0, 3'b111, 32'd10, 32'd20, 32'd0, 1'b0);
        push(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        drain(80);

        // 5: reset while issuing, then while responding
        push(0, 3'b000, 32'd7, 32'd8, 32'd0, 1'b0);
        wait_for(0, 20);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        push(0, 3'b000, 32'd1, 32'd1, 32'd0, 1'b0);
        drain(50);
        rsp_mode = 2;
        push(1, 3'b001, 32'd9, 32'd2, 32'd0, 1'b0);
        wait_for(1, 20);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        rsp_mode = 1;
        push(0, 3'b000, 32'd1, 32'd1, 32'd0, 1'b0);
        drain(50);

        // 6: both requesters held busy; grants must alternate
        for (int n = 0; n < 6; n++) begin
            push_rand(0);
            push_rand(1);
        end
        drain(200);

        // Random traffic with random consumer back-pressure
        rsp_mode = 0;
        for (int n = 0; n < 150; n++) begin
            int r;
            int guard;
            r = $urandom_range(0, NREQ - 1);
            guard = 0;
            while (op_q[r].size() > 2 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            push_rand(r);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        drain(3000);
        rsp_mode = 1;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
